// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator request path.
package falafel_pkg;

  localparam int unsigned MSG_ID_SIZE = 4;
  localparam int unsigned DATA_W      = 32;

  // Upper bound on arbiter width, used only by elaboration checks.
  localparam int unsigned MAX_ARB_PORTS = 16;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] qid;
    logic [DATA_W-1:0]      data;
  } alloc_entry_t;

endpackage

// File: rtl/falafel_rr_arbiter.sv
// Round-robin grant selection; owns the rotating priority pointer.
module falafel_rr_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PORT_IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic                  advance,
  output logic                  grant_valid,
  output logic [PORT_IDX_W-1:0] grant_idx
);

  logic [PORT_IDX_W-1:0] rr_ptr;

  always_comb begin
    int unsigned p;
    p           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      p = int'(rr_ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!grant_valid && req[p]) begin
        grant_valid = 1'b1;
        grant_idx   = PORT_IDX_W'(p);
      end
    end
  end

  // Pointer moves to the port after the winner, so it never exceeds NUM_PORTS-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_ARB_PORTS) begin : g_bad_num_ports
    $error("falafel_rr_arbiter: NUM_PORTS out of range");
  end

  rr_ptr_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(rr_ptr) < NUM_PORTS);

endmodule

// File: rtl/falafel_req_arbiter.sv
// Merges NUM_PORTS tagged request streams into one registered output stream.
module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned PORT_IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic         [NUM_PORTS-1:0]         req_val_i,
  output logic         [NUM_PORTS-1:0]         req_rdy_o,
  input  alloc_entry_t [NUM_PORTS-1:0]         req_data_i,
  output logic                                 out_val_o,
  input  logic                                 out_rdy_i,
  output alloc_entry_t                         out_data_o,
  output logic         [PORT_IDX_W-1:0]        out_port_o
);

  logic                  load_en;
  logic                  grant_valid;
  logic [PORT_IDX_W-1:0] grant_idx;
  logic                  advance;

  assign load_en = !out_val_o || out_rdy_i;
  // rst_ni gates the handshake so no request is acknowledged during reset.
  assign advance = load_en && grant_valid && rst_ni;

  falafel_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_IDX_W(PORT_IDX_W)
  ) u_rr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req        (req_val_i),
    .advance    (advance),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    req_rdy_o = '0;
    if (advance) req_rdy_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_val_o  <= 1'b0;
      out_data_o <= '0;
      out_port_o <= '0;
    end else if (advance) begin
      out_val_o  <= 1'b1;
      out_data_o <= req_data_i[grant_idx];
      out_port_o <= grant_idx;
    end else if (load_en) begin
      out_val_o  <= 1'b0;
    end
  end

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_ARB_PORTS) begin : g_bad_num_ports
    $error("falafel_req_arbiter: NUM_PORTS out of range");
  end

  rdy_onehot0: assert property (@(posedge clk_i) $onehot0(req_rdy_o));

endmodule
